// File: rtl/ext_bus_master.sv
// Host-bus initiator: one request -> 1 or 2 strobed 16-bit beats (setup/strobe/hold); rsp after P (narrow) or 2P+1 (wide) cycles.
// req_ready_o is high only in IDLE, so one request is in flight; all bus/rsp outputs are registered to keep strobes glitch-free.
module ext_bus_master #(
  parameter int ADDR_WIDTH    = 25,
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic                  req_wide_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [31:0]           rsp_rdata_o,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic [15:0]           bus_data_o,
  input  logic [15:0]           bus_data_i,
  output logic                  bus_data_oe_o,
  output logic [1:0]            bus_cs_o,
  output logic                  bus_read_n_o,
  output logic                  bus_write_n_o
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, GAP} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  wr_q, wr_d, wide_q, wide_d, beat_q, beat_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [15:0]           rd_lo_q, rd_lo_d, rd_hi_q, rd_hi_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [15:0]           bus_data_q, bus_data_d;
  logic                  oe_q, oe_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
  logic [1:0]            cs_q, cs_d;
  logic                  active_d;
  logic                  unused_addr_lsb;

  assign unused_addr_lsb = req_addr_i[0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    wide_d      = wide_q;
    beat_d      = beat_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rd_lo_d     = rd_lo_q;
    rd_hi_d     = rd_hi_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;

    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          wr_d    = req_write_i;
          wide_d  = req_wide_i;
          addr_d  = {req_addr_i[ADDR_WIDTH-1:1], 1'b0};
          wdata_d = req_wdata_i;
          beat_d  = 1'b0;
          cnt_d   = 4'(SETUP_CYCLES);
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == 4'd1) begin
          cnt_d   = 4'(STROBE_CYCLES);
          state_d = STROBE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      STROBE: begin
        if (cnt_q == 4'd1) begin
          if (!wr_q) begin
            if (beat_q) rd_hi_d = bus_data_i;
            else        rd_lo_d = bus_data_i;
          end
          cnt_d   = 4'(HOLD_CYCLES);
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        if (cnt_q == 4'd1) begin
          if (wide_q && !beat_q) begin
            state_d = GAP;
          end else begin
            state_d     = IDLE;
            rsp_valid_d = 1'b1;
            if (!wr_q) rsp_rdata_d = {(wide_q ? rd_hi_q : 16'h0000), rd_lo_q};
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      GAP: begin
        beat_d  = 1'b1;
        cnt_d   = 4'(SETUP_CYCLES);
        state_d = SETUP;
      end
      default: state_d = IDLE;
    endcase

    // Bus pins are registered from the next state so they switch with the phase.
    active_d   = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
    bus_addr_d = bus_addr_q;
    if (state_d == SETUP && state_q != SETUP)
      bus_addr_d = beat_d ? addr_d + ADDR_WIDTH'(2) : addr_d;
    bus_data_d = bus_data_q;
    if (active_d && wr_d)
      bus_data_d = beat_d ? wdata_d[31:16] : wdata_d[15:0];
    oe_d   = active_d && wr_d;
    rd_n_d = !(active_d && !wr_d);
    wr_n_d = !(active_d && wr_d);
    cs_d   = (state_d == STROBE) ? 2'b11 : 2'b00;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      wr_q        <= 1'b0;
      wide_q      <= 1'b0;
      beat_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      rd_lo_q     <= 16'h0;
      rd_hi_q     <= 16'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      bus_addr_q  <= '0;
      bus_data_q  <= 16'h0;
      oe_q        <= 1'b0;
      cs_q        <= 2'b00;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      wide_q      <= wide_d;
      beat_q      <= beat_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_lo_q     <= rd_lo_d;
      rd_hi_q     <= rd_hi_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      bus_addr_q  <= bus_addr_d;
      bus_data_q  <= bus_data_d;
      oe_q        <= oe_d;
      cs_q        <= cs_d;
      rd_n_q      <= rd_n_d;
      wr_n_q      <= wr_n_d;
    end
  end

  assign req_ready_o   = (state_q == IDLE);
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign bus_addr_o    = bus_addr_q;
  assign bus_data_o    = bus_data_q;
  assign bus_data_oe_o = oe_q;
  assign bus_cs_o      = cs_q;
  assign bus_read_n_o  = rd_n_q;
  assign bus_write_n_o = wr_n_q;

endmodule

// File: tb/tb_ext_bus_master.sv
// Directed bench for ext_bus_master at S=2, T=4, H=2 (P=8); outputs sampled on the falling edge.
module tb_ext_bus_master;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i, req_ready_o, req_write_i, req_wide_i;
  logic [24:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic [24:0] bus_addr_o;
  logic [15:0] bus_data_o, bus_data_i;
  logic        bus_data_oe_o;
  logic [1:0]  bus_cs_o;
  logic        bus_read_n_o, bus_write_n_o;

  int vectors = 0;
  int miscompares = 0;

  ext_bus_master dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_write_i(req_write_i), .req_wide_i(req_wide_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
    .bus_addr_o(bus_addr_o), .bus_data_o(bus_data_o), .bus_data_i(bus_data_i),
    .bus_data_oe_o(bus_data_oe_o), .bus_cs_o(bus_cs_o),
    .bus_read_n_o(bus_read_n_o), .bus_write_n_o(bus_write_n_o)
  );

  always #5 clk_i = ~clk_i;

  // Responder register file as seen on the pads.
  always @* begin
    case (bus_addr_o)
      25'h0000000: bus_data_i = 16'h50FE;
      25'h000000C: bus_data_i = 16'hAAAA;
      25'h000000E: bus_data_i = 16'h5555;
      default:     bus_data_i = 16'h0000;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Returns 1 time unit after the acceptance edge; the next falling edge is cycle 0.
  task automatic send(input logic w, input logic wd, input logic [24:0] a, input logic [31:0] d);
    int guard = 0;
    @(negedge clk_i);
    req_valid_i = 1'b1; req_write_i = w; req_wide_i = wd; req_addr_i = a; req_wdata_i = d;
    while (!req_ready_o && guard < 50) begin
      @(negedge clk_i);
      guard++;
    end
    check("accept_ready", {31'h0, req_ready_o}, 32'h1);
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, {31'h0, req_ready_o}, 32'h1);
    check({tag, "_rv"},    {31'h0, rsp_valid_o}, 32'h0);
    check({tag, "_rdata"}, rsp_rdata_o, 32'h0);
    check({tag, "_addr"},  {7'h0, bus_addr_o}, 32'h0);
    check({tag, "_data"},  {16'h0, bus_data_o}, 32'h0);
    check({tag, "_oe"},    {31'h0, bus_data_oe_o}, 32'h0);
    check({tag, "_cs"},    {30'h0, bus_cs_o}, 32'h0);
    check({tag, "_rn"},    {31'h0, bus_read_n_o}, 32'h1);
    check({tag, "_wn"},    {31'h0, bus_write_n_o}, 32'h1);
  endtask

  initial begin
    int low_run;
    int rv_seen;
    bit seen_high;
    logic in_b0, in_b1, strobe_win;

    rst_i = 1'b1; req_valid_i = 1'b0; req_write_i = 1'b0; req_wide_i = 1'b0;
    req_addr_i = '0; req_wdata_i = 32'h0;
    repeat (2) @(negedge clk_i);
    check_reset_vals("por");
    rst_i = 1'b0;

    // Narrow write, odd address.
    send(1'b1, 1'b0, 25'h000000B, 32'h00001234);
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk_i);
      check("nw_wn", {31'h0, bus_write_n_o}, (c <= 7) ? 32'h0 : 32'h1);
      check("nw_rn", {31'h0, bus_read_n_o}, 32'h1);
      check("nw_cs", {30'h0, bus_cs_o}, (c >= 2 && c <= 5) ? 32'h3 : 32'h0);
      check("nw_oe", {31'h0, bus_data_oe_o}, (c <= 7) ? 32'h1 : 32'h0);
      check("nw_rv", {31'h0, rsp_valid_o}, (c == 8) ? 32'h1 : 32'h0);
      check("nw_ready", {31'h0, req_ready_o}, (c == 8) ? 32'h1 : 32'h0);
      if (c <= 7) begin
        check("nw_addr", {7'h0, bus_addr_o}, 32'h0000000A);
        check("nw_data", {16'h0, bus_data_o}, 32'h00001234);
      end
      if (c == 8) check("nw_rdata", rsp_rdata_o, 32'h0);
    end

    // Narrow read at 0.
    send(1'b0, 1'b0, 25'h0000000, 32'h0);
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk_i);
      check("nr_rn", {31'h0, bus_read_n_o}, (c <= 7) ? 32'h0 : 32'h1);
      check("nr_wn", {31'h0, bus_write_n_o}, 32'h1);
      check("nr_oe", {31'h0, bus_data_oe_o}, 32'h0);
      check("nr_cs", {30'h0, bus_cs_o}, (c >= 2 && c <= 5) ? 32'h3 : 32'h0);
      check("nr_rv", {31'h0, rsp_valid_o}, (c == 8) ? 32'h1 : 32'h0);
      if (c == 8) check("nr_rdata", rsp_rdata_o, 32'h000050FE);
    end

    // Wide read at 0x0C: beats 0..7, GAP 8, beats 9..16, response 17.
    send(1'b0, 1'b1, 25'h000000C, 32'h0);
    for (int c = 0; c <= 17; c++) begin
      @(negedge clk_i);
      in_b0 = (c <= 7);
      in_b1 = (c >= 9 && c <= 16);
      strobe_win = (c >= 2 && c <= 5) || (c >= 11 && c <= 14);
      check("wr_rn", {31'h0, bus_read_n_o}, (in_b0 || in_b1) ? 32'h0 : 32'h1);
      check("wr_wn", {31'h0, bus_write_n_o}, 32'h1);
      check("wr_oe", {31'h0, bus_data_oe_o}, 32'h0);
      check("wr_cs", {30'h0, bus_cs_o}, strobe_win ? 32'h3 : 32'h0);
      check("wr_addr", {7'h0, bus_addr_o}, (c <= 8) ? 32'h0000000C : 32'h0000000E);
      check("wr_rv", {31'h0, rsp_valid_o}, (c == 17) ? 32'h1 : 32'h0);
      if (c == 16) check("wr_rdata_stable", rsp_rdata_o, 32'h000050FE);
      if (c == 17) check("wr_rdata", rsp_rdata_o, 32'h5555AAAA);
    end

    // Wide write across the top of the address space.
    send(1'b1, 1'b1, 25'h1FFFFFE, 32'hCAFEBEEF);
    for (int c = 0; c <= 17; c++) begin
      @(negedge clk_i);
      in_b0 = (c <= 7);
      in_b1 = (c >= 9 && c <= 16);
      check("ww_wn", {31'h0, bus_write_n_o}, (in_b0 || in_b1) ? 32'h0 : 32'h1);
      check("ww_oe", {31'h0, bus_data_oe_o}, (in_b0 || in_b1) ? 32'h1 : 32'h0);
      if (in_b0) begin
        check("ww_addr0", {7'h0, bus_addr_o}, 32'h01FFFFFE);
        check("ww_data0", {16'h0, bus_data_o}, 32'h0000BEEF);
      end
      if (in_b1) begin
        check("ww_addr1", {7'h0, bus_addr_o}, 32'h00000000);
        check("ww_data1", {16'h0, bus_data_o}, 32'h0000CAFE);
      end
      check("ww_rv", {31'h0, rsp_valid_o}, (c == 17) ? 32'h1 : 32'h0);
      if (c == 17) check("ww_rdata", rsp_rdata_o, 32'h5555AAAA);
    end

    // Back-to-back narrow writes with req_valid_i held high.
    @(negedge clk_i);
    req_valid_i = 1'b1; req_write_i = 1'b1; req_wide_i = 1'b0;
    req_addr_i = 25'h0000020; req_wdata_i = 32'h00001111;
    @(posedge clk_i);
    #1 req_wdata_i = 32'h00005678;
    low_run = 0;
    seen_high = 1'b0;
    for (int c = 0; c <= 18; c++) begin
      @(negedge clk_i);
      if (c == 3) check("b2b_data1", {16'h0, bus_data_o}, 32'h00001111);
      if (c == 8) begin
        check("b2b_ready", {31'h0, req_ready_o}, 32'h1);
        check("b2b_rv1", {31'h0, rsp_valid_o}, 32'h1);
      end
      if (c == 9) begin
        check("b2b_accepted", {31'h0, req_ready_o}, 32'h0);
        check("b2b_data2", {16'h0, bus_data_o}, 32'h00005678);
        req_valid_i = 1'b0;
      end
      if (c == 17) check("b2b_rv2", {31'h0, rsp_valid_o}, 32'h1);
      if (c >= 6 && !seen_high) begin
        if (bus_cs_o == 2'b00) low_run++;
        else seen_high = 1'b1;
      end
    end
    check("b2b_cs_gap", low_run, 32'd5);

    // Reset in cycle 3 of a read.
    send(1'b0, 1'b0, 25'h0000000, 32'h0);
    repeat (4) @(negedge clk_i);
    rst_i = 1'b1;
    #1 check_reset_vals("arst");
    @(negedge clk_i);
    rst_i = 1'b0;
    rv_seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_i);
      if (rsp_valid_o) rv_seen++;
    end
    check("arst_no_rsp", rv_seen, 32'd0);
    check("arst_ready", {31'h0, req_ready_o}, 32'h1);
    send(1'b0, 1'b0, 25'h0000000, 32'h0);
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk_i);
      check("post_rv", {31'h0, rsp_valid_o}, (c == 8) ? 32'h1 : 32'h0);
      if (c == 8) check("post_rdata", rsp_rdata_o, 32'h000050FE);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ext_bus_master.md
# ext_bus_master

Initiator for the 16-bit asynchronous-strobe host bus that the FPGA register interface responds to. It converts a single-request valid/ready command (16- or 32-bit, read or write) into bus cycles using chip select, read and write strobes, with programmable setup, strobe and hold phases. It sits in bench/bridge logic that must drive the FPGA register file the way the ARM host does, and returns read data as one response pulse.

## Interface
- ADDR_WIDTH, 25, bus byte-address width; bit 0 is always driven 0.
- SETUP_CYCLES, 2, cycles with address, strobe and data valid before chip select rises; legal range 1..15.
- STROBE_CYCLES, 4, cycles chip select is held at 2'b11; legal range 1..15. The responder needs at least 4 cycles of its own clock.
- HOLD_CYCLES, 2, cycles address, strobe and data are held after chip select falls; legal range 1..15.
- clk_i  in  1  single clock.
- rst_i  in  1  reset, asynchronous, active-high.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  high exactly when the FSM is IDLE.
- req_write_i  in  1  1 = write, 0 = read.
- req_wide_i  in  1  1 = 32-bit access as two 16-bit beats, 0 = one beat.
- req_addr_i  in  ADDR_WIDTH  byte address; bit 0 is ignored.
- req_wdata_i  in  32  write data; a narrow write uses [15:0].
- rsp_valid_o  out  1  one-cycle completion pulse, for reads and writes.
- rsp_rdata_o  out  32  read result, {high beat, low beat}.
- bus_addr_o  out  ADDR_WIDTH  bus address.
- bus_data_o  out  16  write data to the pad buffer.
- bus_data_i  in  16  read data from the pad buffer.
- bus_data_oe_o  out  1  pad output enable.
- bus_cs_o  out  2  chip select; 2'b00 idle, 2'b11 active.
- bus_read_n_o  out  1  active-low read strobe.
- bus_write_n_o  out  1  active-low write strobe.

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD, GAP.
- A down-counter loads the phase length on each phase entry. The phase ends when the counter reaches 1.
- On acceptance (req_valid_i && req_ready_o at a rising edge):
  - the FSM latches write, wide, {addr[ADDR_WIDTH-1:1],1'b0} and wdata;
  - it clears the beat index and enters SETUP;
  - later changes on the req_* inputs are ignored.
- SETUP:
  - bus_addr_o carries the beat address;
  - for a read, bus_read_n_o=0; for a write, bus_write_n_o=0, bus_data_oe_o=1 and bus_data_o carries the beat data;
  - bus_cs_o=2'b00.
- STROBE: same signals as SETUP, plus bus_cs_o=2'b11.
- At the edge that ends the last STROBE cycle, a read captures bus_data_i into the low half (beat 0) or the high half (beat 1) of the read register.
- HOLD: same signals as SETUP, with bus_cs_o=2'b00.
- End of HOLD:
  - beat 0 of a wide access goes to GAP;
  - otherwise the FSM goes to IDLE and asserts rsp_valid_o for that one IDLE cycle.
- GAP (exactly 1 cycle):
  - all strobes deasserted, bus_data_oe_o=0;
  - bus_addr_o still carries beat 0's address (it changes when SETUP is entered);
  - then SETUP for beat 1.
- Beat data and address:
  - beat 0 data is wdata[15:0]; beat 1 data is wdata[31:16];
  - beat 1 address is beat 0 address + 2, modulo 2^ADDR_WIDTH (0x1FFFFFE wraps to 0x0000000).
- Results:
  - a narrow read returns rsp_rdata_o[31:16]=0;
  - a write leaves rsp_rdata_o unchanged;
  - rsp_rdata_o updates only when rsp_valid_o is asserted and is stable otherwise.
- All bus_* outputs and rsp_* outputs come from flops, so there are no glitches on the strobes.
- bus_data_oe_o is never 1 during a read or in IDLE or GAP.

## Timing
- Reset values (held for as long as rst_i is high):
  - FSM in IDLE, so req_ready_o=1;
  - rsp_valid_o=0, rsp_rdata_o=0;
  - bus_addr_o=0, bus_data_o=0, bus_data_oe_o=0;
  - bus_cs_o=2'b00, bus_read_n_o=1, bus_write_n_o=1.
- Reset in the middle of a transfer abandons it immediately (asynchronously): no rsp_valid_o pulse, and the strobes are released in the same cycle.
- Let acceptance be edge k, and P = SETUP_CYCLES + STROBE_CYCLES + HOLD_CYCLES.
- Narrow transfer:
  - strobe low in cycles k..k+P-1;
  - chip select high in cycles k+SETUP_CYCLES..k+SETUP_CYCLES+STROBE_CYCLES-1;
  - rsp_valid_o high in cycle k+P.
- Wide transfer: rsp_valid_o high in cycle k+2P+1.
- Back-to-back:
  - a new request can be accepted in the rsp_valid_o cycle;
  - the minimum chip-select-low gap between transactions is HOLD_CYCLES+1+SETUP_CYCLES cycles.
- Throughput: one request in flight; req_ready_o=0 from the edge after acceptance until the transfer completes.

## Test plan
Defaults S=2, T=4, H=2 (P=8) apply throughout.
- Narrow write, addr 0x0000B, data 0x1234 -> bus_addr_o=0x0000A; bus_write_n_o=0 in cycles 0..7; bus_cs_o=2'b11 in cycles 2..5; bus_data_o=0x1234 with oe=1 in cycles 0..7; rsp_valid_o in cycle 8; rsp_rdata_o unchanged.
- Narrow read, addr 0x0, bus model drives 0x50FE -> bus_read_n_o=0 in cycles 0..7; oe=0 throughout; rsp_rdata_o=0x000050FE with rsp_valid_o in cycle 8.
- Wide read, addr 0x0C, bus returns 0xAAAA then 0x5555 -> beats at 0x0C then 0x0E; exactly 1 GAP cycle with all strobes high; rsp_rdata_o=0x5555AAAA in cycle 17.
- Wide write, addr 0x1FFFFFE, data 0xCAFEBEEF -> beat 0 writes 0xBEEF at 0x1FFFFFE; beat 1 writes 0xCAFE at 0x0000000.
- req_valid_i held high for two narrow writes -> the second is accepted in cycle 8; bus_cs_o stays 2'b00 for 5 consecutive cycles between the two strobe windows.
- rst_i pulsed in cycle 3 of a read -> all outputs at reset values asynchronously; no rsp_valid_o; req_ready_o=1 after release; the next request completes normally.
